popcount_decoder16: RTL and testbench
=====================================

POPCOUNT_DECODER16 -- requirements
Module: popcount_decoder16

Interface
REQ-001 Parameter SAT, default 1: overflow handling for counts 17..31 (1 = clamp to 16, 0 = treat as 0).
REQ-002 Parameter REVERSE, default 0: thermometer fill direction (0 = from y0 upward, 1 = from y15 downward).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: in_valid  input  1  count word offered.
REQ-006 Port: in_ready  output  1  count word accepted when in_valid & in_ready at a clk edge ("accept").
REQ-007 Port: x0..x4  input  1 each  5-bit unsigned count; x0 is the LSB.
REQ-008 Port: out_valid  output  1  thermometer word valid.
REQ-009 Port: out_ready  input  1  downstream takes word when out_valid & out_ready at a clk edge ("take").
REQ-010 Port: y0..y15  output  1 each  16-bit thermometer word, the inverse of the 16-input population counter.
REQ-011 Port: ser_out  output  1  serial unary pulse stream; one high cycle per counted one.
REQ-012 Port: ser_busy  output  1  high while the serial burst is in progress.
REQ-013 Port: err  output  1  sticky overflow flag.

Function
REQ-014 The block SHALL compute eff_k from each accepted count k: k when k<=16; for k>=17, 16 when SAT=1 and 0 when SAT=0.
REQ-015 When REVERSE=0, the word SHALL have yi=1 exactly for i<eff_k; when REVERSE=1, yi=1 exactly for i>=16-eff_k; all other bits SHALL be 0.
REQ-016 The parallel path SHALL be two register stages: S1 holds eff_k; S2 holds the decoded word and drives y0..y15 and out_valid.
REQ-017 S2 SHALL advance when ~out_valid | out_ready; S1 SHALL move into S2 only when S1 is full and S2 advances.
REQ-018 in_ready SHALL equal ~ser_busy & (~S1_full | S2_advance); it SHALL have no combinational dependence on in_valid or x0..x4.
REQ-019 With out_ready held high, out_valid SHALL rise exactly 2 cycles after the accept edge, and back-to-back accepts SHALL be possible when no serial burst is active.
REQ-020 While out_valid & ~out_ready, y0..y15 and out_valid SHALL stay stable; no word SHALL be dropped or duplicated.
REQ-021 On accept with eff_k>0, ser_out SHALL be high for exactly eff_k consecutive cycles, starting the cycle after accept; ser_busy SHALL be high in exactly those cycles.
REQ-022 On accept with eff_k=0, ser_out and ser_busy SHALL stay low, and in_ready SHALL be governed only by the pipeline term.
REQ-023 The serial down-counter SHALL be 5 bits wide, SHALL never wrap below 0, and SHALL drop ser_busy in the cycle after its last pulse.
REQ-024 in_ready SHALL be low for every cycle in which ser_busy is high; the next accept is possible in the first cycle ser_busy is low.
REQ-025 err SHALL set on the cycle after accepting any k>=17, regardless of SAT, and SHALL clear only on reset.
REQ-026 Serial and parallel outputs of one accepted count SHALL be independent; backpressure on out_ready SHALL NOT stall ser_out.

Reset
REQ-027 When rst is high at a clk edge, S1, S2, the serial counter and err SHALL clear, regardless of in-flight words or bursts.
REQ-028 The cycle after reset, the outputs SHALL be: out_valid=0, y0..y15=0, ser_out=0, ser_busy=0, err=0, in_ready=1.
REQ-029 While rst is high, no accept SHALL occur, and in_valid during reset SHALL be ignored.
REQ-030 Reset asserted mid-burst SHALL terminate ser_out within the same edge, with no residual pulses after reset deasserts.

Verification
REQ-031 Accept k=5 with SAT=1, REVERSE=0 and out_ready=1 -> out_valid rises 2 cycles later with y0..y4=1 and y5..y15=0; ser_out is high for 5 cycles starting the cycle after accept; in_ready is low for those 5 cycles.
REQ-032 Accept k=16 -> all y=1 and 16 serial pulses; then accept k=0 the first cycle ser_busy falls -> the next word is all-zero, with no pulses.
REQ-033 Accept k=20 with SAT=1 -> word all ones, 16 pulses, err=1 held; repeat with SAT=0 -> word all zero, no pulses, err=1.
REQ-034 Run with REVERSE=1 and k=3 -> y13..y15=1 and all other bits 0.
REQ-035 Issue k=0,0,0 back-to-back with out_ready low for 4 cycles -> in_ready falls after two words are buffered; releasing out_ready delivers three all-zero words in order, with no loss.
REQ-036 Accept k=10 and assert rst 4 cycles later -> ser_out drops at the reset edge, and all outputs match REQ-028 afterwards.

Source files
------------

// File: rtl/popcount_decoder16.sv
// -----------------------------------------------------------------------------
// popcount_decoder16
//
// Inverse of a 16-input population counter. A 5-bit count k arrives on a
// valid/ready handshake and produces two independent results:
//   * parallel: a 16-bit thermometer word with eff_k ones, delivered through
//     a two-stage elastic pipeline (S1 holds eff_k, S2 holds the decoded word);
//   * serial:   a burst of eff_k consecutive high cycles on ser_out.
// Counts 17..31 are out of range: they clamp to 16 (SAT=1) or collapse to 0
// (SAT=0), and in both cases set the sticky err flag.
//
// Parameters
//   SAT      1 = clamp counts 17..31 to 16, 0 = treat them as 0
//   REVERSE  0 = fill ones from y0 upward, 1 = fill ones from y15 downward
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous reset, active high
//   in_valid    count word offered
//   in_ready    count word accepted on in_valid & in_ready
//   x0..x4      5-bit unsigned count, x0 = LSB
//   out_valid   thermometer word valid
//   out_ready   downstream takes the word on out_valid & out_ready
//   y0..y15     thermometer word
//   ser_out     serial unary pulse stream, one high cycle per counted one
//   ser_busy    high while a serial burst is in progress
//   err         sticky out-of-range flag, cleared only by reset
// -----------------------------------------------------------------------------
module popcount_decoder16 #(
  parameter int SAT     = 1,
  parameter int REVERSE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  output logic out_valid,
  input  logic out_ready,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5,
  output logic y6,
  output logic y7,
  output logic y8,
  output logic y9,
  output logic y10,
  output logic y11,
  output logic y12,
  output logic y13,
  output logic y14,
  output logic y15,
  output logic ser_out,
  output logic ser_busy,
  output logic err
);

  localparam logic [4:0] K_MAX = 5'd16;

  logic [4:0]  k_in;
  logic [4:0]  eff_k;
  logic        k_over;
  logic        accept;

  logic        s1_full;
  logic [4:0]  s1_k;
  logic        s2_valid;
  logic [15:0] s2_word;
  logic        s2_adv;
  logic        s1_to_s2;

  logic [4:0]  ser_cnt;
  logic        err_q;

  assign k_in   = {x4, x3, x2, x1, x0};
  assign k_over = (k_in > K_MAX);

  // Effective count after out-of-range handling.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here via the if/else chain) so no latch is inferred.
  always_comb begin
    if (!k_over) begin
      eff_k = k_in;
    end else if (SAT != 0) begin
      eff_k = K_MAX;
    end else begin
      eff_k = 5'd0;
    end
  end

  // Thermometer decode of a count 0..16.
  function automatic logic [15:0] thermo(input logic [4:0] n);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (REVERSE == 0) begin
        w[i] = (i < int'(n));
      end else begin
        w[i] = (i >= 16 - int'(n));
      end
    end
    return w;
  endfunction

  // Handshake. S2 can take a new word when it is empty or being drained;
  // S1 can take a new count when it is empty or is handing its count to S2.
  // The serial burst holds off new counts so one burst never overlaps the next.
  // in_ready is also held low during reset so nothing counts as accepted then.
  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_to_s2 = s1_full & s2_adv;
  assign ser_busy = (ser_cnt != 5'd0);
  assign in_ready = ~rst & ~ser_busy & (~s1_full | s2_adv);
  assign accept   = in_valid & in_ready;

  // Stage 1: effective count.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full <= 1'b0;
      s1_k    <= '0;
    end else if (accept) begin
      s1_full <= 1'b1;
      s1_k    <= eff_k;
    end else if (s1_to_s2) begin
      s1_full <= 1'b0;
    end
  end

  // Stage 2: decoded word. An empty S2 shows all zeros on y.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_full;
      s2_word  <= s1_full ? thermo(s1_k) : '0;
    end
  end

  // Serial burst: load eff_k on accept, count down to zero, one pulse per
  // cycle while non-zero. It only decrements when non-zero, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_cnt <= '0;
    end else if (accept) begin
      ser_cnt <= eff_k;
    end else if (ser_busy) begin
      ser_cnt <= ser_cnt - 5'd1;
    end
  end

  // Sticky flag: the raw count is checked, so it sets regardless of SAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && k_over) begin
      err_q <= 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign ser_out   = ser_busy;
  assign err       = err_q;

  assign y0  = s2_word[0];
  assign y1  = s2_word[1];
  assign y2  = s2_word[2];
  assign y3  = s2_word[3];
  assign y4  = s2_word[4];
  assign y5  = s2_word[5];
  assign y6  = s2_word[6];
  assign y7  = s2_word[7];
  assign y8  = s2_word[8];
  assign y9  = s2_word[9];
  assign y10 = s2_word[10];
  assign y11 = s2_word[11];
  assign y12 = s2_word[12];
  assign y13 = s2_word[13];
  assign y14 = s2_word[14];
  assign y15 = s2_word[15];

endmodule

// File: tb/tb_popcount_decoder16.sv
// -----------------------------------------------------------------------------
// tb_popcount_decoder16
//
// Two instances: d0 (SAT=1, REVERSE=0) and d1 (SAT=0, REVERSE=1), each with
// its own handshake signals. A per-instance reference model keeps a queue of
// words accepted but not yet taken (with the cycle each was accepted) and the
// number of serial pulses still owed; every cycle the DUT outputs are compared
// against it. Directed sequences cover the documented scenarios, then both
// instances receive random traffic.
// -----------------------------------------------------------------------------
module tb_popcount_decoder16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        armed = 1'b0;
  logic        in_valid  [2];
  logic [4:0]  xk        [2];
  logic        out_ready [2];
  wire         in_ready  [2];
  wire         out_valid [2];
  wire         ser_out   [2];
  wire         ser_busy  [2];
  wire         err       [2];
  wire  [15:0] y         [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  popcount_decoder16 #(.SAT(1), .REVERSE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .x0(xk[0][0]), .x1(xk[0][1]), .x2(xk[0][2]), .x3(xk[0][3]), .x4(xk[0][4]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .y0(y[0][0]), .y1(y[0][1]), .y2(y[0][2]), .y3(y[0][3]),
    .y4(y[0][4]), .y5(y[0][5]), .y6(y[0][6]), .y7(y[0][7]),
    .y8(y[0][8]), .y9(y[0][9]), .y10(y[0][10]), .y11(y[0][11]),
    .y12(y[0][12]), .y13(y[0][13]), .y14(y[0][14]), .y15(y[0][15]),
    .ser_out(ser_out[0]), .ser_busy(ser_busy[0]), .err(err[0])
  );

  popcount_decoder16 #(.SAT(0), .REVERSE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .x0(xk[1][0]), .x1(xk[1][1]), .x2(xk[1][2]), .x3(xk[1][3]), .x4(xk[1][4]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .y0(y[1][0]), .y1(y[1][1]), .y2(y[1][2]), .y3(y[1][3]),
    .y4(y[1][4]), .y5(y[1][5]), .y6(y[1][6]), .y7(y[1][7]),
    .y8(y[1][8]), .y9(y[1][9]), .y10(y[1][10]), .y11(y[1][11]),
    .y12(y[1][12]), .y13(y[1][13]), .y14(y[1][14]), .y15(y[1][15]),
    .ser_out(ser_out[1]), .ser_busy(ser_busy[1]), .err(err[1])
  );

  // ---------------- reference model ----------------
  function automatic bit sat_of(int i);
    return (i == 0);
  endfunction

  function automatic bit rev_of(int i);
    return (i == 1);
  endfunction

  function automatic int eff_of(int i, int k);
    if (k <= 16) return k;
    return sat_of(i) ? 16 : 0;
  endfunction

  // Ones in the low eff bits, or in the high eff bits when reversed.
  function automatic logic [15:0] word_of(int i, int k);
    int e;
    int m;
    e = eff_of(i, k);
    if (!rev_of(i)) begin
      m = (1 << e) - 1;
    end else begin
      m = 32'hFFFF ^ ((1 << (16 - e)) - 1);
    end
    return 16'(m);
  endfunction

  typedef struct {
    logic [15:0] word;
    int          acc;
  } item_t;

  for (genvar g = 0; g < 2; g++) begin : mon
    item_t q[$];
    int    rem      = 0;
    bit    err_m    = 0;
    bit    post_rst = 0;
    int    pulses   = 0;
    int    takes    = 0;

    always @(negedge clk) begin
      int    held;
      bit    exp_ov;
      string p;
      item_t it;
      if (armed) begin
        p      = $sformatf("d%0d", g);
        held   = q.size();
        exp_ov = 1'b0;
        // A word shows on the outputs two cycles after its accept cycle.
        if (held > 0) exp_ov = (cyc >= q[0].acc + 2);
        check({p, " out_valid"}, 32'(out_valid[g]), 32'(exp_ov));
        if (exp_ov && out_valid[g] === 1'b1)
          check({p, " y"}, 32'(y[g]), 32'(q[0].word));
        if (post_rst) check({p, " y after reset"}, 32'(y[g]), 32'd0);
        check({p, " ser_out"},  32'(ser_out[g]),  32'(rem > 0));
        check({p, " ser_busy"}, 32'(ser_busy[g]), 32'(rem > 0));
        check({p, " err"},      32'(err[g]),      32'(err_m));
        if (!rst)
          check({p, " in_ready"}, 32'(in_ready[g]),
                32'(rem == 0 && (held < 2 || out_ready[g] === 1'b1)));

        if (ser_out[g] === 1'b1) pulses++;
        if (out_valid[g] === 1'b1 && out_ready[g]) takes++;

        post_rst = 1'b0;
        if (rst) begin
          q.delete();
          rem      = 0;
          err_m    = 1'b0;
          post_rst = 1'b1;
        end else begin
          if (exp_ov && out_ready[g]) void'(q.pop_front());
          if (rem > 0) rem--;
          if (in_valid[g] && in_ready[g] === 1'b1) begin
            it.word = word_of(g, int'(xk[g]));
            it.acc  = cyc;
            q.push_back(it);
            rem = eff_of(g, int'(xk[g]));
            if (xk[g] >= 5'd17) err_m = 1'b1;
          end
        end
      end
    end
  end

  function automatic int pulses_of(int i);
    return (i == 0) ? mon[0].pulses : mon[1].pulses;
  endfunction

  function automatic int takes_of(int i);
    return (i == 0) ? mon[0].takes : mon[1].takes;
  endfunction

  function automatic int held_of(int i);
    return (i == 0) ? mon[0].q.size() : mon[1].q.size();
  endfunction

  // ---------------- stimulus helpers ----------------
  // Offer count k until accepted; acc returns the accept cycle.
  task automatic send(input int i, input int k, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    in_valid[i] = 1'b1;
    xk[i]       = 5'(k);
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready[i] === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
    check($sformatf("d%0d accept k=%0d", i, k), 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_word(input int i, input logic [15:0] exp, input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (out_valid[i] === 1'b1) found = 1'b1;
    end
    check({tag, " seen"}, 32'(found), 32'd1);
    if (found) check(tag, 32'(y[i]), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int i);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 60 && !idle; n++) begin
      @(negedge clk);
      if (ser_busy[i] === 1'b0) idle = 1'b1;
    end
    check($sformatf("d%0d idle", i), 32'(idle), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rand_drive(input int i);
    for (int n = 0; n < 600; n++) begin
      in_valid[i]  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) xk[i] = 5'($urandom_range(17, 31));
      else if ($urandom_range(0, 1) == 0) xk[i] = 5'($urandom_range(0, 3));
      else xk[i] = 5'($urandom_range(0, 16));
      out_ready[i] = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int a1;
    int a2;
    int p0;
    int t0;
    bit [3:0] exp_ir;

    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      xk[i]        = 5'd0;
      out_ready[i] = 1'b1;
    end

    // Reset, with in_valid asserted to show it is ignored.
    rst = 1'b1;
    in_valid[0] = 1'b1;
    xk[0] = 5'd7;
    repeat (3) @(posedge clk);
    #1;
    armed = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready",  32'(in_ready[0]),  32'd1);
    check("reset out_valid", 32'(out_valid[0]), 32'd0);
    check("reset y",         32'(y[0]),         32'd0);
    check("reset ser_out",   32'(ser_out[0]),   32'd0);
    check("reset ser_busy",  32'(ser_busy[0]),  32'd0);
    check("reset err",       32'(err[0]),       32'd0);
    @(posedge clk); #1;

    // k=5: five pulses starting right after accept, word y0..y4.
    p0 = pulses_of(0);
    send(0, 5, a1);
    check("k5 ser_out after accept", 32'(ser_out[0]), 32'd1);
    check("k5 in_ready during burst", 32'(in_ready[0]), 32'd0);
    wait_word(0, 16'h001F, "k5 word");
    repeat (10) @(posedge clk);
    #1;
    check("k5 pulses", 32'(pulses_of(0) - p0), 32'd5);

    // k=16 then k=0 accepted the first cycle ser_busy is low.
    p0 = pulses_of(0);
    send(0, 16, a1);
    wait_word(0, 16'hFFFF, "k16 word");
    send(0, 0, a2);
    check("k0 accept gap after k16", 32'(a2 - a1), 32'd17);
    wait_word(0, 16'h0000, "k0 word");
    repeat (4) @(posedge clk);
    #1;
    check("k16+k0 pulses", 32'(pulses_of(0) - p0), 32'd16);

    // k=20 with SAT=1 (d0) and SAT=0 (d1).
    p0 = pulses_of(0);
    send(0, 20, a1);
    wait_word(0, 16'hFFFF, "k20 sat word");
    check("k20 sat err", 32'(err[0]), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("k20 sat pulses", 32'(pulses_of(0) - p0), 32'd16);
    check("k20 sat err held", 32'(err[0]), 32'd1);
    p0 = pulses_of(1);
    send(1, 20, a1);
    wait_word(1, 16'h0000, "k20 nosat word");
    check("k20 nosat err", 32'(err[1]), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("k20 nosat pulses", 32'(pulses_of(1) - p0), 32'd0);

    // REVERSE=1, k=3: y13..y15.
    send(1, 3, a1);
    wait_word(1, 16'hE000, "reverse k3 word");

    // Three zero counts into a stalled output: two fit, the third waits.
    wait_idle(0);
    t0 = takes_of(0);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    xk[0]        = 5'd0;
    exp_ir       = 4'b0011;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("stall in_ready %0d", j), 32'(in_ready[0]), 32'(exp_ir[j]));
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("release in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("stall words delivered", 32'(takes_of(0) - t0), 32'd3);

    // Reset four cycles into a k=10 burst.
    send(0, 10, a1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("burst before reset", 32'(ser_out[0]), 32'd1);
    @(posedge clk); #1;
    check("ser_out at reset edge",  32'(ser_out[0]),  32'd0);
    check("ser_busy at reset edge", 32'(ser_busy[0]), 32'd0);
    rst = 1'b0;
    p0 = pulses_of(0);
    @(negedge clk);
    check("post reset in_ready",  32'(in_ready[0]),  32'd1);
    check("post reset out_valid", 32'(out_valid[0]), 32'd0);
    check("post reset y",         32'(y[0]),         32'd0);
    check("post reset err d0",    32'(err[0]),       32'd0);
    check("post reset err d1",    32'(err[1]),       32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("no pulses after reset", 32'(pulses_of(0) - p0), 32'd0);

    // Random traffic on both instances.
    fork
      rand_drive(0);
      rand_drive(1);
    join

    // Drain.
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (40) @(posedge clk);
    #1;
    check("d0 drained", 32'(held_of(0)), 32'd0);
    check("d1 drained", 32'(held_of(1)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
